// File: rtl/fd_full_adder.sv
// Single-bit full adder with registered sum/carry, a combinational result copy,
// and LSB-first serial chaining through the registered carry.
module fd_full_adder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    input  logic             ser_mode,
    input  logic             ser_first,
    output logic             So_c,
    output logic             Co_c,
    output logic             So,
    output logic             Co,
    output logic             valid,
    output logic [CNT_W-1:0] op_count
);

    logic             r_so;
    logic             r_co;
    logic             r_valid;
    logic [CNT_W-1:0] r_op_count;
    logic             w_cin_sel;
    logic [1:0]       w_sum;

    // Carry-in source: registered carry between serial bits, external Cin otherwise
    always_comb begin
        w_cin_sel = Cin;
        if (ser_mode && !ser_first) begin
            w_cin_sel = r_co;
        end else begin
            w_cin_sel = Cin;
        end
    end

    assign w_sum = {1'b0, A} + {1'b0, B} + {1'b0, w_cin_sel};

    assign So_c     = w_sum[0];
    assign Co_c     = w_sum[1];
    assign So       = r_so;
    assign Co       = r_co;
    assign valid    = r_valid;
    assign op_count = r_op_count;

    // Result, strobe and operation-count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_so       <= 1'b0;
            r_co       <= 1'b0;
            r_valid    <= 1'b0;
            r_op_count <= {CNT_W{1'b0}};
        end else if (en) begin
            r_so       <= w_sum[0];
            r_co       <= w_sum[1];
            r_valid    <= 1'b1;
            r_op_count <= r_op_count + CNT_W'(1);
        end else begin
            r_so       <= r_so;
            r_co       <= r_co;
            r_valid    <= 1'b0;
            r_op_count <= r_op_count;
        end
    end

endmodule

// File: tb/tb_fd_full_adder.sv
// Scoreboard bench for fd_full_adder: directed vectors push hand-computed results,
// a negedge monitor pops and compares whenever valid is high.
module tb_fd_full_adder;

    logic       clk = 1'b0;
    logic       rst_n, en, A, B, Cin, ser_mode, ser_first;
    logic       So_c, Co_c, So, Co, valid;
    logic [7:0] op_count;
    logic       So_c2, Co_c2, So2, Co2, valid2;
    logic [1:0] op_count2;

    typedef struct {
        logic so;
        logic co;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   exp_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    fd_full_adder #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .Cin(Cin),
        .ser_mode(ser_mode), .ser_first(ser_first),
        .So_c(So_c), .Co_c(Co_c), .So(So), .Co(Co), .valid(valid), .op_count(op_count)
    );

    fd_full_adder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .Cin(Cin),
        .ser_mode(ser_mode), .ser_first(ser_first),
        .So_c(So_c2), .Co_c(Co_c2), .So(So2), .Co(Co2), .valid(valid2), .op_count(op_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one accepted operation and record its expected registered result
    task automatic op(input logic a, input logic b, input logic c, input logic sm,
                      input logic sf, input logic eso, input logic eco);
        exp_t e;
        @(negedge clk);
        A = a; B = b; Cin = c; ser_mode = sm; ser_first = sf; en = 1'b1;
        exp_cnt++;
        e.so = eso; e.co = eco; e.cnt = exp_cnt;
        exp_q.push_back(e);
        #1;
        check("So_c", int'(So_c), int'(eso));
        check("Co_c", int'(Co_c), int'(eco));
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_So"}, int'(So), 0);
        check({tag, "_Co"}, int'(Co), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_cnt"}, int'(op_count), 0);
        check({tag, "_cnt2"}, int'(op_count2), 0);
        check({tag, "_Co2"}, int'(Co2), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; A = 1'b1; B = 1'b1; Cin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        exp_cnt = 0;
        check_zero("reset");
    endtask

    // Monitor: every valid cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("So", int'(So), int'(e.so));
                check("Co", int'(Co), int'(e.co));
                check("op_count", int'(op_count), e.cnt % 256);
                check("op_count_w2", int'(op_count2), e.cnt % 4);
                check("valid_w2", int'(valid2), 1);
                check("So_w2", int'(So2), int'(e.so));
            end
        end
    end

    initial begin
        logic [2:0] v;
        logic [3:0] sa, sb;
        rst_n = 1'b0; en = 1'b0; A = 1'b1; B = 1'b1; Cin = 1'b0;
        ser_mode = 1'b0; ser_first = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("init");
        #1;
        check("init_So_c", int'(So_c), 0);
        check("init_Co_c", int'(Co_c), 1);
        ser_mode = 1'b1; A = 1'b1; B = 1'b0; Cin = 1'b1;
        #1;
        check("init_ser_So_c", int'(So_c), 1);
        check("init_ser_Co_c", int'(Co_c), 0);
        rst_n = 1'b1;

        // Exhaustive parallel truth table, {A,B,Cin} = 000..111
        op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        check("exh_count", int'(op_count), 8);
        check("exh_count_w2", int'(op_count2), 0);

        // Hold: registered result stays while en=0, combinational tracks inputs
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        en = 1'b0; A = 1'b0; B = 1'b0; Cin = 1'b0;
        @(negedge clk);
        #1;
        check("hold_valid", int'(valid), 0);
        check("hold_So", int'(So), 0);
        check("hold_Co", int'(Co), 1);
        check("hold_So_c", int'(So_c), 0);
        check("hold_cnt", int'(op_count), 9);

        // Serial 1011 + 0110, Cin=0: sums 1,0,0,0 carry-out 1
        sa = 4'b1011; sb = 4'b0110;
        op(sa[0], sb[0], 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        op(sa[1], sb[1], 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        op(sa[2], sb[2], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        op(sa[3], sb[3], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Serial 1111 + 0000, Cin=1, with a pause mid-word
        sa = 4'b1111; sb = 4'b0000;
        op(sa[0], sb[0], 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        op(sa[1], sb[1], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("pause_Co", int'(Co), 1);
        op(sa[2], sb[2], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        op(sa[3], sb[3], 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        check("ser2_final_Co", int'(Co), 1);

        // ser_first ignored in parallel mode (Co=1 would otherwise be irrelevant anyway)
        op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Reset mid-word clears the carry register
        op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        op(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Counter wrap on the 2-bit instance: 1,2,3,0,1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            v = 3'(i + 1);
            op(v[0], v[1], 1'b0, 1'b0, 1'b0, v[0] ^ v[1], v[0] & v[1]);
        end
        idle();
        repeat (2) @(negedge clk);
        check("wrap_cnt_w2", int'(op_count2), 1);
        check("wrap_cnt", int'(op_count), 5);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fd_full_adder.md
# fd_full_adder

Single-bit full adder with registered outputs and an optional bit-serial carry-chaining mode. It adds A, B and a carry-in and produces a sum bit and a carry-out one clock after the operands are accepted. A combinational copy of the result is also provided for glue logic. It is the 1-bit arithmetic primitive for the dev-board datapath and for LSB-first serial adders.

## Interface
- CNT_W, 8: width of the accepted-operation counter.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  in  1  operand strobe; the adder accepts A, B and Cin on a rising edge where en=1.
- A  in  1  operand bit A.
- B  in  1  operand bit B.
- Cin  in  1  external carry-in.
- ser_mode  in  1  1 = carry-in comes from the internal carry register, except on the first bit of a word.
- ser_first  in  1  in serial mode, marks the LSB of a word; Cin is used for that bit.
- So_c  out  1  combinational sum: A ^ B ^ cin_sel.
- Co_c  out  1  combinational carry: majority(A, B, cin_sel).
- So  out  1  registered sum bit.
- Co  out  1  registered carry-out. This is also the internal carry register used in serial mode.
- valid  out  1  1 for exactly the cycle after each accepted operation.
- op_count  out  CNT_W  number of accepted operations, modulo 2^CNT_W.

## Operation
- Carry-in selection: cin_sel = (ser_mode & ~ser_first) ? Co : Cin.
- Arithmetic: 2-bit result {co, so} = A + B + cin_sel, with all operands zero-extended.
- Truth table (A B cin_sel -> So Co):
  - 000 -> 0 0
  - 001 -> 1 0
  - 010 -> 1 0
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- So_c and Co_c always reflect the current inputs and the current Co register. They are purely combinational and unaffected by en.
- Rising edge with rst_n=0: So=0, Co=0, valid=0, op_count=0. Reset overrides en.
- Rising edge with rst_n=1 and en=1:
  - So <= so and Co <= co.
  - valid <= 1.
  - op_count <= op_count + 1, wrapping from 2^CNT_W-1 to 0.
- Rising edge with rst_n=1 and en=0: So, Co and op_count hold; valid <= 0.
- Serial mode:
  - Present one bit pair per accepted cycle, LSB first, with ser_first=1 on the LSB.
  - The carry between bits is taken from the Co register.
  - After the MSB, Co is the word's carry-out.
- ser_first is ignored when ser_mode=0.
- ser_mode may change between any two operations with no side effects.
- No X-propagation tolerance is required on inputs; inputs are assumed driven.

## Timing
- Latency: 1 cycle. Operands accepted at edge k appear on So/Co after edge k, with valid=1 during cycle k+1.
- Throughput: one operation per cycle. Back-to-back en=1 is allowed indefinitely.
- Serial carry loop: bit n+1 uses the Co registered at bit n's edge, so consecutive bits may be strobed on consecutive cycles.
- If en drops mid-word in serial mode, the Co register holds. The word resumes correctly on the next accepted bit.
- Reset mid-word clears Co. The next word must start with ser_first=1.
- Reset has no asynchronous effect. Outputs change only at clock edges, except So_c/Co_c.
- Every output is 0 after reset. So_c/Co_c equal the function of the current inputs with Co=0.

## Test plan
- Exhaustive parallel mode: apply all 8 {A,B,Cin} combinations 000..111 with en=1 for one cycle each. So/Co must follow the truth table one cycle later, e.g. 111 -> So=1, Co=1 and 011 -> So=0, Co=1. op_count must reach 8.
- Hold: apply A=1, B=1, Cin=0 with en=1, then en=0 with inputs changed to 000. So=0 and Co=1 must hold, valid must go 1 then 0, and So_c must track the new inputs (0).
- Serial 4-bit add, 0b1011 + 0b0110, Cin=0, LSB first with ser_first on bit 0. The So sequence must be 1,0,0,0 and the final Co must be 1 (result 0b10001).
- Serial carry-in: 0b1111 + 0b0000 with Cin=1 on the first bit. So must be 0,0,0,0 and the final Co must be 1.
- Reset mid-word: set Co=1 via 1+1, then assert rst_n=0 for one edge with en=1. So, Co, valid and op_count must all be 0. The next serial bit with ser_first=0 and A=B=0 must give So=0.
- Counter wrap: with CNT_W=2, issue 5 accepted operations. op_count must read 1,2,3,0,1.
